// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory loader
package imem_pkg;

    localparam int IMEM_DEPTH = 1024;
    localparam int XLEN       = 32;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        FLUSH,
        DONE,
        ERR
    } loader_state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] waddr;
        logic [XLEN-1:0] wdata;
    } imem_wr_t;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - little-endian byte-to-word assembler for header and data words
module byte_assembler
    import imem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic [7:0]      i_data,
    input  logic            i_fire,
    output logic            o_word_valid,
    output logic [XLEN-1:0] o_word
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_low;

    // The 4th byte is forwarded straight into the word so it is usable on its own edge.
    assign o_word_valid = i_fire && (r_byte_cnt == 2'd3);
    assign o_word       = {i_data, r_low};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_byte_cnt <= 2'd0;
            r_low      <= 24'd0;
        end else if (i_fire) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
                2'd0:    r_low[7:0]   <= i_data;
                2'd1:    r_low[15:8]  <= i_data;
                2'd2:    r_low[23:16] <= i_data;
                default: r_low        <= r_low;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader that writes the instruction memory
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = $clog2(DEPTH) + 1;

    loader_state_t   r_state;
    imem_wr_t        r_wr;
    logic            r_done;
    logic            r_error;
    logic            r_cpu_hold;
    logic [IDX_W-1:0] r_word_idx;
    logic [XLEN-1:0] r_n_words;

    logic            w_fire;
    logic            w_clr;
    logic            w_word_valid;
    logic [XLEN-1:0] w_word;
    logic            w_last;

    assign in_ready = !rst && (r_state == HDR || r_state == DATA);
    assign w_fire   = in_valid && in_ready;
    assign w_clr    = start && (r_state == DONE || r_state == ERR);
    assign w_last   = ({{(XLEN-IDX_W){1'b0}}, r_word_idx} == (r_n_words - XLEN'(1)));

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_data       (in_data),
        .i_fire       (w_fire),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HDR;
            r_wr       <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_word_idx <= '0;
            r_n_words  <= '0;
        end else begin
            r_wr.we <= 1'b0;
            unique case (r_state)
                HDR: begin
                    if (w_word_valid) begin
                        r_n_words <= w_word;
                        if (w_word == '0) begin
                            r_state <= FLUSH;
                        end else if (w_word > XLEN'(DEPTH)) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_wr.we    <= 1'b1;
                        r_wr.waddr <= XLEN'({r_word_idx, 2'b00});
                        r_wr.wdata <= w_word;
                        r_word_idx <= r_word_idx + IDX_W'(1);
                        if (w_last) begin
                            r_state <= FLUSH;
                        end
                    end
                end
                // The final write pulse is on the port during this cycle, so the core stays held.
                FLUSH: begin
                    r_state    <= DONE;
                    r_done     <= 1'b1;
                    r_cpu_hold <= 1'b0;
                end
                DONE, ERR: begin
                    if (start) begin
                        r_state    <= HDR;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_word_idx <= '0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    assign we       = r_wr.we;
    assign waddr    = ADDR_W'(r_wr.waddr);
    assign wdata    = r_wr.wdata;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule
